// File: rtl/lsu.sv
`default_nettype none
// ============================================================================
// Module   : lsu
// Purpose  : Memory-stage load/store unit. Accepts one memory op, issues it on a
//            req/gnt/rvalid data port, and returns extended load data to writeback.
// Revision : 1.0 - initial release
// ============================================================================
module lsu #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ex_valid,
  input  logic            ex_is_load,
  input  logic            ex_is_store,
  input  logic [2:0]      ex_funct3,
  input  logic [XLEN-1:0] ex_addr,
  input  logic [XLEN-1:0] ex_wdata,
  input  logic [4:0]      ex_rd,
  input  logic            flush,
  output logic            lsu_busy,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [XLEN-1:0] dmem_addr,
  output logic [3:0]      dmem_wstrb,
  output logic [XLEN-1:0] dmem_wdata,
  input  logic            dmem_gnt,
  input  logic            dmem_rvalid,
  input  logic [XLEN-1:0] dmem_rdata,
  output logic            wb_valid,
  output logic [4:0]      wb_rd,
  output logic [XLEN-1:0] wb_data,
  output logic            done,
  output logic            exc_valid,
  output logic [1:0]      exc_code,
  output logic [XLEN-1:0] exc_addr
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } state_t;

  state_t state, state_nx;

  logic            accept, illegal, misaligned;
  logic [3:0]      st_strb;
  logic [XLEN-1:0] st_data;
  logic [XLEN-1:0] ld_shift, ld_data;

  logic [XLEN-1:0] addr_q, wdata_q, wb_data_q, exc_addr_q;
  logic [3:0]      wstrb_q;
  logic [2:0]      funct3_q;
  logic [1:0]      off_q, exc_code_q;
  logic [4:0]      rd_q, wb_rd_q;
  logic            is_load_q, we_q, kill_q;
  logic            wb_valid_q, done_q, exc_valid_q;

  always_comb begin
    accept     = (state == IDLE) & ex_valid & (ex_is_load | ex_is_store) & ~flush;
    illegal    = (ex_is_load & ex_is_store) | (ex_funct3 == 3'b011) |
                 (ex_funct3[2:1] == 2'b11) | (ex_is_store & (ex_funct3[2:1] == 2'b10));
    misaligned = ((ex_funct3[1:0] == 2'b01) & ex_addr[0]) |
                 ((ex_funct3[1:0] == 2'b10) & (ex_addr[1:0] != 2'b00));

    st_strb = 4'b1111;
    st_data = ex_wdata;
    case (ex_funct3[1:0])
      2'b00: begin
        st_strb = 4'b0001 << ex_addr[1:0];
        st_data = {4{ex_wdata[7:0]}};
      end
      2'b01: begin
        st_strb = 4'b0011 << ex_addr[1:0];
        st_data = {2{ex_wdata[15:0]}};
      end
      default: ;
    endcase

    ld_shift = dmem_rdata >> {off_q, 3'b000};
    case (funct3_q)
      3'b000:  ld_data = {{24{ld_shift[7]}}, ld_shift[7:0]};
      3'b100:  ld_data = {24'h0, ld_shift[7:0]};
      3'b001:  ld_data = {{16{ld_shift[15]}}, ld_shift[15:0]};
      3'b101:  ld_data = {16'h0, ld_shift[15:0]};
      default: ld_data = ld_shift;
    endcase
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (accept && !illegal && !misaligned) state_nx = REQ;
      // A grant commits the access even if a flush arrives in the same cycle.
      REQ: begin
        if (dmem_gnt)   state_nx = is_load_q ? WAIT : IDLE;
        else if (flush) state_nx = IDLE;
      end
      WAIT: if (dmem_rvalid) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      funct3_q    <= '0;
      off_q       <= '0;
      rd_q        <= '0;
      is_load_q   <= 1'b0;
      we_q        <= 1'b0;
      kill_q      <= 1'b0;
      wb_valid_q  <= 1'b0;
      done_q      <= 1'b0;
      exc_valid_q <= 1'b0;
      exc_code_q  <= '0;
      exc_addr_q  <= '0;
      wb_rd_q     <= '0;
      wb_data_q   <= '0;
    end else begin
      wb_valid_q  <= 1'b0;
      done_q      <= 1'b0;
      exc_valid_q <= 1'b0;

      if (accept) begin
        if (illegal || misaligned) begin
          exc_valid_q <= 1'b1;
          exc_code_q  <= illegal ? 2'b11 : (ex_is_load ? 2'b01 : 2'b10);
          exc_addr_q  <= ex_addr;
        end else begin
          addr_q    <= {ex_addr[XLEN-1:2], 2'b00};
          off_q     <= ex_addr[1:0];
          funct3_q  <= ex_funct3;
          rd_q      <= ex_rd;
          is_load_q <= ex_is_load;
          we_q      <= ex_is_store;
          wstrb_q   <= ex_is_store ? st_strb : 4'b0000;
          wdata_q   <= st_data;
          kill_q    <= 1'b0;
        end
      end

      if (state == REQ && dmem_gnt && !is_load_q) done_q <= 1'b1;

      // A killed load still drains its response so the port stays in sync.
      if (state == WAIT) begin
        if (flush) kill_q <= 1'b1;
        if (dmem_rvalid && !(kill_q || flush)) begin
          wb_valid_q <= 1'b1;
          done_q     <= 1'b1;
          wb_rd_q    <= rd_q;
          wb_data_q  <= ld_data;
        end
      end
    end
  end

  assign lsu_busy   = (state != IDLE);
  assign dmem_req   = (state == REQ);
  assign dmem_we    = we_q;
  assign dmem_addr  = addr_q;
  assign dmem_wstrb = wstrb_q;
  assign dmem_wdata = wdata_q;
  assign wb_valid   = wb_valid_q;
  assign wb_rd      = wb_rd_q;
  assign wb_data    = wb_data_q;
  assign done       = done_q;
  assign exc_valid  = exc_valid_q;
  assign exc_code   = exc_code_q;
  assign exc_addr   = exc_addr_q;

endmodule
`default_nettype wire

// File: tb/tb_lsu.sv
`default_nettype none
// ============================================================================
// Module   : tb_lsu
// Purpose  : Scoreboard-driven self-checking bench for lsu with a delay-programmable
//            data-memory responder.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lsu;

  logic        clk = 1'b0;
  logic        rst, ex_valid, ex_is_load, ex_is_store, flush;
  logic [2:0]  ex_funct3;
  logic [31:0] ex_addr, ex_wdata;
  logic [4:0]  ex_rd;
  logic        lsu_busy, dmem_req, dmem_we, dmem_gnt, dmem_rvalid;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_wstrb;
  logic        wb_valid, done, exc_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data, exc_addr;
  logic [1:0]  exc_code;

  always #5 clk = ~clk;

  lsu #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_is_load(ex_is_load),
    .ex_is_store(ex_is_store), .ex_funct3(ex_funct3), .ex_addr(ex_addr),
    .ex_wdata(ex_wdata), .ex_rd(ex_rd), .flush(flush), .lsu_busy(lsu_busy),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wstrb(dmem_wstrb), .dmem_wdata(dmem_wdata), .dmem_gnt(dmem_gnt),
    .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata), .wb_valid(wb_valid),
    .wb_rd(wb_rd), .wb_data(wb_data), .done(done), .exc_valid(exc_valid),
    .exc_code(exc_code), .exc_addr(exc_addr)
  );

  typedef struct packed {
    logic        wb;
    logic        dn;
    logic        exc;
    logic [1:0]  code;
    logic [31:0] eaddr;
    logic [4:0]  rd;
    logic [31:0] data;
  } res_t;

  res_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Responder: grant after gnt_wait REQ cycles, rvalid rv_wait cycles after the
  // cycle following the grant.
  int          gnt_wait = 0, rv_wait = 0, req_cycles = 0, rv_cnt = 0;
  logic        pend_rv = 1'b0;
  logic [31:0] mem_word = 32'h0;

  initial begin
    dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = 32'h0;
    forever begin
      @(posedge clk); #1;
      dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
      if (pend_rv) begin
        if (rv_cnt == 0) begin
          dmem_rvalid = 1'b1; dmem_rdata = mem_word; pend_rv = 1'b0;
        end else rv_cnt--;
      end
      if (dmem_req) begin
        if (req_cycles >= gnt_wait) begin
          dmem_gnt = 1'b1; req_cycles = 0;
          if (!dmem_we) begin pend_rv = 1'b1; rv_cnt = rv_wait; end
        end else req_cycles++;
      end else req_cycles = 0;
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  function automatic res_t exp_done();
    res_t e; e = '0; e.dn = 1'b1; return e;
  endfunction

  function automatic res_t exp_wb(input logic [4:0] rd, input logic [31:0] d);
    res_t e; e = '0; e.wb = 1'b1; e.dn = 1'b1; e.rd = rd; e.data = d; return e;
  endfunction

  function automatic res_t exp_exc(input logic [1:0] code, input logic [31:0] a);
    res_t e; e = '0; e.exc = 1'b1; e.code = code; e.eaddr = a; return e;
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [1:0] o,
                                           input logic [31:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[8*o +: 8];
    h = o[1] ? w[31:16] : w[15:0];
    case (f3)
      3'b000:  return {{24{b[7]}}, b};
      3'b100:  return {24'h0, b};
      3'b001:  return {{16{h[15]}}, h};
      3'b101:  return {16'h0, h};
      default: return w;
    endcase
  endfunction

  // Presents one op for a single cycle; returns one cycle after the accept edge.
  task automatic drive_op(input logic ld, input logic st, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] wd, input logic [4:0] rd);
    ex_valid = 1'b1; ex_is_load = ld; ex_is_store = st; ex_funct3 = f3;
    ex_addr = a; ex_wdata = wd; ex_rd = rd;
    tick();
    ex_valid = 1'b0; ex_is_load = 1'b0; ex_is_store = 1'b0;
  endtask

  // Waits for the next result pulse and reports it with the cycle it appeared in.
  task automatic collect(input int start, output res_t r, output int lat);
    r = '0; lat = start;
    while (!(wb_valid || done || exc_valid) && lat < start + 60) begin
      tick(); lat++;
    end
    r.wb = wb_valid; r.dn = done; r.exc = exc_valid;
    if (exc_valid) begin r.code = exc_code; r.eaddr = exc_addr; end
    if (wb_valid)  begin r.rd = wb_rd; r.data = wb_data; end
  endtask

  task automatic test_reset();
    rst = 1'b1; tick(); tick();
    n_checks++;
    if ({lsu_busy, dmem_req, dmem_we, dmem_wstrb, dmem_addr, dmem_wdata, wb_valid, wb_rd,
         wb_data, done, exc_valid, exc_code, exc_addr} !== '0) begin
      n_fail++; $display("FAIL reset_outputs: busy=%b req=%b addr=%h wb=%b done=%b exc=%b, all required 0",
                         lsu_busy, dmem_req, dmem_addr, wb_valid, done, exc_valid);
    end
    rst = 1'b0; tick();
  endtask

  task automatic test_store_lanes();
    logic [2:0]  f3 [4]  = '{3'b010, 3'b000, 3'b001, 3'b000};
    logic [31:0] ad [4]  = '{32'h100, 32'h103, 32'h102, 32'h205};
    logic [31:0] wd [4]  = '{32'hDEADBEEF, 32'h000000A5, 32'h1234BEEF, 32'h77665544};
    logic [3:0]  stb [4] = '{4'b1111, 4'b1000, 4'b1100, 4'b0010};
    logic [31:0] rw [4]  = '{32'hDEADBEEF, 32'hA5A5A5A5, 32'hBEEFBEEF, 32'h44444444};
    logic [31:0] ra [4]  = '{32'h100, 32'h100, 32'h100, 32'h204};
    res_t r, e;
    int   lat;
    gnt_wait = 0;
    for (int i = 0; i < 4; i++) begin
      sb.push_back(exp_done());
      drive_op(1'b0, 1'b1, f3[i], ad[i], wd[i], 5'd0);
      n_checks++;
      if ({dmem_req, dmem_we, dmem_wstrb, dmem_addr, dmem_wdata, lsu_busy} !==
          {1'b1, 1'b1, stb[i], ra[i], rw[i], 1'b1}) begin
        n_fail++; $display("FAIL store_req[%0d]: req=%b we=%b strb=%b addr=%h wdata=%h busy=%b, required strb=%b addr=%h wdata=%h",
                           i, dmem_req, dmem_we, dmem_wstrb, dmem_addr, dmem_wdata, lsu_busy, stb[i], ra[i], rw[i]);
      end
      collect(1, r, lat);
      e = sb.pop_front();
      n_checks++;
      if (r !== e || lat != 2) begin
        n_fail++; $display("FAIL store_done[%0d]: got %h at cycle %0d, required %h at cycle 2", i, r, lat, e);
      end
      tick();
      n_checks++;
      if ({wb_valid, done, exc_valid, lsu_busy, dmem_req} !== 5'b0) begin
        n_fail++; $display("FAIL store_idle[%0d]: wb=%b done=%b exc=%b busy=%b req=%b, required all 0",
                           i, wb_valid, done, exc_valid, lsu_busy, dmem_req);
      end
    end
  endtask

  task automatic test_load_ext();
    res_t r, e;
    int   lat;
    logic busy_ok;
    logic [2:0]  fs [5] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010};
    logic [2:0]  f3;
    logic [1:0]  o;
    // Test-plan byte loads: rvalid three cycles after the grant.
    for (int k = 0; k < 2; k++) begin
      gnt_wait = 0; rv_wait = 2; mem_word = 32'h12804567;
      sb.push_back(exp_wb(k == 0 ? 5'd7 : 5'd9, k == 0 ? 32'hFFFFFF80 : 32'h00000080));
      drive_op(1'b1, 1'b0, k == 0 ? 3'b000 : 3'b100, 32'h102, 32'h0, k == 0 ? 5'd7 : 5'd9);
      busy_ok = 1'b1;
      for (int c = 1; c <= 4; c++) begin
        if (lsu_busy !== 1'b1 || wb_valid !== 1'b0) busy_ok = 1'b0;
        if (c < 4) tick();
      end
      n_checks++;
      if (busy_ok !== 1'b1) begin
        n_fail++; $display("FAIL load_busy[%0d]: busy dropped or early wb during REQ/WAIT, got %b required 1", k, busy_ok);
      end
      collect(4, r, lat);
      e = sb.pop_front();
      n_checks++;
      if (r !== e || lat != 5) begin
        n_fail++; $display("FAIL load_byte[%0d]: got %h at cycle %0d, required %h at cycle 5", k, r, lat, e);
      end
      tick();
    end
    // Randomised widths, offsets and wait states checked against the reference extractor.
    for (int i = 0; i < 10; i++) begin
      f3 = fs[$urandom_range(0, 4)];
      o  = 2'($urandom_range(0, 3));
      if (f3[1:0] == 2'b01) o[0] = 1'b0;
      if (f3 == 3'b010) o = 2'b00;
      gnt_wait = $urandom_range(0, 2); rv_wait = $urandom_range(0, 3);
      mem_word = $urandom;
      sb.push_back(exp_wb(5'(i + 1), ref_load(f3, o, mem_word)));
      drive_op(1'b1, 1'b0, f3, 32'h800 + 32'(16 * i) + {30'h0, o}, 32'h0, 5'(i + 1));
      collect(1, r, lat);
      e = sb.pop_front();
      n_checks++;
      if (r !== e || lat != 3 + gnt_wait + rv_wait) begin
        n_fail++; $display("FAIL load_rand[%0d] f3=%b o=%0d: got %h at cycle %0d, required %h at cycle %0d",
                           i, f3, o, r, lat, e, 3 + gnt_wait + rv_wait);
      end
      tick();
    end
  endtask

  task automatic test_exceptions();
    logic        ld [6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    logic        st [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    logic [2:0]  f3 [6] = '{3'b001, 3'b010, 3'b011, 3'b000, 3'b100, 3'b010};
    logic [31:0] ad [6] = '{32'h101, 32'h102, 32'h300, 32'h304, 32'h308, 32'h203};
    logic [1:0]  cd [6] = '{2'b01, 2'b10, 2'b11, 2'b11, 2'b11, 2'b01};
    res_t r, e;
    int   lat;
    for (int i = 0; i < 6; i++) begin
      sb.push_back(exp_exc(cd[i], ad[i]));
      drive_op(ld[i], st[i], f3[i], ad[i], 32'h5A5A5A5A, 5'd3);
      n_checks++;
      if ({dmem_req, lsu_busy} !== 2'b00) begin
        n_fail++; $display("FAIL exc_noaccess[%0d]: req=%b busy=%b, required 0 0", i, dmem_req, lsu_busy);
      end
      collect(1, r, lat);
      e = sb.pop_front();
      n_checks++;
      if (r !== e || lat != 1) begin
        n_fail++; $display("FAIL exc[%0d]: got %h at cycle %0d, required %h at cycle 1", i, r, lat, e);
      end
      tick();
      n_checks++;
      if ({exc_valid, dmem_req, lsu_busy} !== 3'b000 || exc_addr !== ad[i]) begin
        n_fail++; $display("FAIL exc_after[%0d]: exc=%b req=%b busy=%b addr=%h, required 0 0 0 addr=%h",
                           i, exc_valid, dmem_req, lsu_busy, exc_addr, ad[i]);
      end
    end
  endtask

  task automatic test_gnt_delay();
    res_t r, e;
    int   lat;
    logic stable;
    gnt_wait = 4; rv_wait = 0; mem_word = 32'hCAFEF00D;
    sb.push_back(exp_wb(5'd12, 32'hCAFEF00D));
    drive_op(1'b1, 1'b0, 3'b010, 32'h340, 32'h0, 5'd12);
    stable = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      if (dmem_req !== 1'b1 || dmem_addr !== 32'h340 || dmem_we !== 1'b0) stable = 1'b0;
      tick();
    end
    n_checks++;
    if (stable !== 1'b1) begin
      n_fail++; $display("FAIL gnt_delay_hold: req/addr not held through wait states, got %b required 1", stable);
    end
    n_checks++;
    if ({dmem_req, lsu_busy} !== 2'b01) begin
      n_fail++; $display("FAIL gnt_delay_wait: req=%b busy=%b, required 0 1", dmem_req, lsu_busy);
    end
    collect(6, r, lat);
    e = sb.pop_front();
    n_checks++;
    if (r !== e || lat != 7) begin
      n_fail++; $display("FAIL gnt_delay_wb: got %h at cycle %0d, required %h at cycle 7", r, lat, e);
    end
    tick();
  endtask

  task automatic test_flush();
    res_t r, e;
    int   lat;
    logic quiet, busy4, busy5;
    // Flush in IDLE blocks the accept.
    gnt_wait = 0; rv_wait = 0;
    flush = 1'b1;
    drive_op(1'b0, 1'b1, 3'b010, 32'h500, 32'h11111111, 5'd0);
    flush = 1'b0;
    quiet = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      if (dmem_req || lsu_busy || wb_valid || done || exc_valid) quiet = 1'b0;
      tick();
    end
    n_checks++;
    if (quiet !== 1'b1) begin
      n_fail++; $display("FAIL flush_idle: activity after flushed accept, got %b required 1", quiet);
    end
    // Flush in REQ without a grant drops the request.
    gnt_wait = 3;
    drive_op(1'b1, 1'b0, 3'b010, 32'h504, 32'h0, 5'd4);
    flush = 1'b1; tick(); flush = 1'b0;
    n_checks++;
    if ({dmem_req, lsu_busy} !== 2'b00) begin
      n_fail++; $display("FAIL flush_req: req=%b busy=%b, required 0 0", dmem_req, lsu_busy);
    end
    quiet = 1'b1;
    for (int c = 2; c <= 7; c++) begin
      if (wb_valid || done || exc_valid || dmem_req) quiet = 1'b0;
      tick();
    end
    n_checks++;
    if (quiet !== 1'b1) begin
      n_fail++; $display("FAIL flush_req_quiet: pulse after dropped request, got %b required 1", quiet);
    end
    // Flush coincident with a store grant still retires the store.
    gnt_wait = 0;
    sb.push_back(exp_done());
    drive_op(1'b0, 1'b1, 3'b010, 32'h508, 32'h22222222, 5'd0);
    flush = 1'b1; tick(); flush = 1'b0;
    collect(2, r, lat);
    e = sb.pop_front();
    n_checks++;
    if (r !== e || lat != 2) begin
      n_fail++; $display("FAIL flush_gnt_store: got %h at cycle %0d, required %h at cycle 2", r, lat, e);
    end
    tick();
    // Flush in WAIT: the response is consumed silently.
    gnt_wait = 0; rv_wait = 2; mem_word = 32'h33333333;
    drive_op(1'b1, 1'b0, 3'b010, 32'h50C, 32'h0, 5'd5);
    tick();
    flush = 1'b1; tick(); flush = 1'b0;
    quiet = 1'b1; busy4 = 1'b0; busy5 = 1'b1;
    for (int c = 3; c <= 8; c++) begin
      if (wb_valid || done || exc_valid) quiet = 1'b0;
      if (c == 4) busy4 = lsu_busy;
      if (c == 5) busy5 = lsu_busy;
      tick();
    end
    n_checks++;
    if ({quiet, busy4, busy5} !== 3'b110) begin
      n_fail++; $display("FAIL flush_wait: quiet=%b busy@rvalid=%b busy@after=%b, required 1 1 0", quiet, busy4, busy5);
    end
    // Unit is usable again afterwards.
    rv_wait = 0; mem_word = 32'h0000FFFE;
    sb.push_back(exp_wb(5'd6, 32'hFFFFFFFE));
    drive_op(1'b1, 1'b0, 3'b001, 32'h510, 32'h0, 5'd6);
    collect(1, r, lat);
    e = sb.pop_front();
    n_checks++;
    if (r !== e || lat != 3) begin
      n_fail++; $display("FAIL flush_recover: got %h at cycle %0d, required %h at cycle 3", r, lat, e);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    logic quiet;
    gnt_wait = 0; rv_wait = 3; mem_word = 32'h44444444;
    drive_op(1'b1, 1'b0, 3'b010, 32'h600, 32'h0, 5'd8);
    tick();
    rst = 1'b1; tick(); rst = 1'b0;
    n_checks++;
    if ({dmem_req, lsu_busy} !== 2'b00) begin
      n_fail++; $display("FAIL reset_mid: req=%b busy=%b, required 0 0", dmem_req, lsu_busy);
    end
    quiet = 1'b1;
    for (int c = 3; c <= 9; c++) begin
      if (wb_valid || done || exc_valid || lsu_busy) quiet = 1'b0;
      tick();
    end
    n_checks++;
    if (quiet !== 1'b1) begin
      n_fail++; $display("FAIL reset_stray_rvalid: activity after reset, got %b required 1", quiet);
    end
  endtask

  task automatic test_back_to_back();
    logic        ld [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic [2:0]  f3 [4] = '{3'b010, 3'b010, 3'b000, 3'b101};
    logic [31:0] ad [4] = '{32'h400, 32'h404, 32'h409, 32'h40E};
    logic [31:0] mw [4] = '{32'h0, 32'h89ABCDEF, 32'h0, 32'hF00D1234};
    res_t r, e;
    int   idx = 0, got = 0, cyc = 0, last = -1;
    gnt_wait = 0; rv_wait = 0;
    for (int i = 0; i < 4; i++)
      sb.push_back(ld[i] ? exp_wb(5'(20 + i), ref_load(f3[i], ad[i][1:0], mw[i])) : exp_done());
    while (got < 4 && cyc < 200) begin
      if (idx < 4) begin
        ex_valid = 1'b1; ex_is_load = ld[idx]; ex_is_store = ~ld[idx]; ex_funct3 = f3[idx];
        ex_addr = ad[idx]; ex_wdata = 32'h0BADF00D; ex_rd = 5'(20 + idx);
        if (!lsu_busy) begin mem_word = mw[idx]; idx++; end
      end else begin
        ex_valid = 1'b0; ex_is_load = 1'b0; ex_is_store = 1'b0;
      end
      if (wb_valid || done || exc_valid) begin
        r = '0; r.wb = wb_valid; r.dn = done; r.exc = exc_valid;
        if (exc_valid) begin r.code = exc_code; r.eaddr = exc_addr; end
        if (wb_valid)  begin r.rd = wb_rd; r.data = wb_data; end
        e = sb.pop_front();
        n_checks++;
        if (r !== e) begin
          n_fail++; $display("FAIL b2b[%0d]: got %h, required %h", got, r, e);
        end
        got++; last = cyc;
      end
      tick(); cyc++;
    end
    ex_valid = 1'b0; ex_is_load = 1'b0; ex_is_store = 1'b0;
    n_checks++;
    if (got != 4 || last != 10 || sb.size() != 0) begin
      n_fail++; $display("FAIL b2b_throughput: results=%0d last_cycle=%0d left=%0d, required 4 10 0",
                         got, last, sb.size());
    end
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; ex_valid = 1'b0; ex_is_load = 1'b0; ex_is_store = 1'b0;
    ex_funct3 = 3'b000; ex_addr = 32'h0; ex_wdata = 32'h0; ex_rd = 5'd0;
    test_reset();
    test_store_lanes();
    test_load_ext();
    test_exceptions();
    test_gnt_delay();
    test_flush();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/lsu.md
Name: lsu

Overview:
- Memory-stage load/store unit.
- Consumes the execute-stage effective address (the ALU ADD result) and the store data (rs2).
- Issues one access at a time on a req/gnt/rvalid data-memory port.
- Returns sign/zero-extended load data to writeback; stalls the pipeline while an access is in flight.

Parameters:
XLEN, 32 (from riscv_pkg), data/address width; only 32 is supported.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  synchronous active-high reset.
ex_valid  in  1  execute stage presents a memory op this cycle.
ex_is_load  in  1  op is a load.
ex_is_store  in  1  op is a store.
ex_funct3  in  3  RV32I width/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
ex_addr  in  XLEN  effective address (ALU result).
ex_wdata  in  XLEN  store data (rs2).
ex_rd  in  5  load destination register.
flush  in  1  kill the current/incoming op (branch mispredict/trap).
lsu_busy  out  1  high while state != IDLE; upstream holds its op and ex_valid is ignored.
dmem_req  out  1  access request.
dmem_we  out  1  1 = store.
dmem_addr  out  XLEN  word-aligned address ({addr[31:2],2'b00}).
dmem_wstrb  out  4  byte enables.
dmem_wdata  out  XLEN  lane-replicated store data.
dmem_gnt  in  1  request accepted this cycle.
dmem_rvalid  in  1  load data valid.
dmem_rdata  in  XLEN  load word.
wb_valid  out  1  one-cycle pulse: load data ready (loads only).
wb_rd  out  5  destination register.
wb_data  out  XLEN  extended load data.
done  out  1  one-cycle pulse: op retired (load or store).
exc_valid  out  1  one-cycle pulse: op rejected.
exc_code  out  2  01 load misaligned, 10 store misaligned, 11 illegal op.
exc_addr  out  XLEN  faulting ex_addr.

Behaviour:
- Reset: state IDLE. All outputs 0, including dmem_* outputs, wb_*, done, exc_*.
- FSM states: IDLE, REQ, WAIT.
- IDLE accept: condition is ex_valid & (ex_is_load | ex_is_store) & ~flush.
  - On accept, capture addr, funct3, rd, wdata and type.
- Illegal op, checked at accept:
  - both ex_is_load and ex_is_store set, or funct3 in {011,110,111}, or store with funct3 in {100,101};
  - no memory access; exc_valid=1, exc_code=11 next cycle; remain IDLE.
- Misaligned, checked at accept: H/HU with addr[0]=1, or W with addr[1:0]!=0.
  - no memory access; exc_valid next cycle, code 01 (load) or 10 (store), exc_addr=ex_addr; remain IDLE.
- Legal accept: go to REQ.
- REQ:
  - dmem_req=1 with registered addr/we/wstrb/wdata, held stable until dmem_gnt.
  - Store with gnt: go to IDLE; done=1 the next cycle.
  - Load with gnt: go to WAIT.
- WAIT:
  - dmem_req=0.
  - On dmem_rvalid: capture and extend data, go to IDLE.
  - wb_valid=done=1 the next cycle, with wb_rd and wb_data.
  - rvalid arrives no earlier than the cycle after gnt. rvalid in IDLE or REQ is ignored.
- Store lanes, with o=addr[1:0]:
  - SB: wstrb=4'b0001<<o, wdata={4{wdata[7:0]}}.
  - SH: wstrb=4'b0011<<o, wdata={2{wdata[15:0]}}.
  - SW: wstrb=4'b1111, wdata unchanged.
- Load extract: w=rdata>>(8*o).
  - LB: sext(w[7:0]). LBU: zext(w[7:0]).
  - LH: sext(w[15:0]). LHU: zext(w[15:0]).
  - LW: rdata.
- Latency (accept at cycle 0, gnt at first REQ cycle 1):
  - store: done at cycle 2.
  - load with rvalid at cycle 2: wb_valid at cycle 3.
  - Gnt/rvalid wait states extend this 1:1.
- lsu_busy: registered, =1 in REQ and WAIT.
  - Not asserted on the accept cycle or on exception cycles; the upstream advances on the accept edge.
- flush:
  - In IDLE, blocks the accept.
  - In REQ, if gnt is coincident the access is committed and its done still fires; without gnt, drop req next cycle and return to IDLE with no done.
  - In WAIT, latch a kill flag; still wait for rvalid, then return to IDLE with wb_valid and done suppressed.
- Pulses wb_valid/done/exc_valid are one cycle and mutually exclusive.
- wb_data, wb_rd and exc_addr hold their last value otherwise.
- rst mid-operation: return to IDLE immediately, dmem_req=0 the next cycle, no pulses. A pending rvalid after reset is ignored.

Test Plan:
- SW addr 0x100, data 0xDEADBEEF, gnt immediate -> req cycle 1 with wstrb 1111, addr 0x100; done at cycle 2; wb_valid stays 0.
- SB addr 0x103, data 0x000000A5 -> wstrb 1000, wdata 0xA5A5A5A5, dmem_addr 0x100.
- LB addr 0x102, rdata 0x12804567, rvalid 3 cycles after gnt -> wb_data 0xFFFFFF80, wb_rd echoed; the same stimulus as LBU -> wb_data 0x00000080; lsu_busy high throughout REQ/WAIT.
- LH at 0x101 -> exc_valid, code 01, exc_addr 0x101, no dmem_req. SW at 0x102 -> code 10. funct3=011 -> code 11.
- Load with gnt delayed 4 cycles -> dmem_req and dmem_addr held stable for 4 cycles. flush in WAIT, rvalid 2 cycles later -> no wb_valid, no done; IDLE afterwards.
- rst asserted in WAIT -> dmem_req and lsu_busy are 0 the next cycle; a stray rvalid afterwards produces no wb_valid.
